// File: rtl/adder_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : adder_share_arbiter
// Description : Round-robin arbiter and two-stage pipeline that time-shares a
//               single registered WIDTH-bit adder among NREQ requesters.
//               Each accepted operand pair carries its requester ID and the
//               sum is returned with that ID two cycles after the transfer.
//               Response backpressure stalls the whole pipeline.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               req_valid/ready - per-requester handshake (ready one-hot)
//               req_a/req_b     - packed operands, requester i at [i*WIDTH +: WIDTH]
//               rsp_valid/ready - result handshake
//               rsp_id/rsp_sum  - requester index and WIDTH+1-bit unsigned sum
//               busy            - any pipeline stage holds valid data
// Revision    : 1.0 - initial release
// ============================================================================
module adder_share_arbiter #(
  parameter int WIDTH = 138,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH:0]        rsp_sum,
  output logic                  busy
);

  localparam logic [IDW-1:0] LAST_ID  = IDW'(NREQ - 1);
  localparam logic [IDW:0]   NREQ_EXT = (IDW + 1)'(NREQ);

  // Stage 1: operand registers
  logic             s1_valid_q, s1_valid_d;
  logic [IDW-1:0]   s1_id_q,    s1_id_d;
  logic [WIDTH-1:0] a_q,        a_d;
  logic [WIDTH-1:0] b_q,        b_d;
  // Stage 2: sum registers
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q,    rsp_id_d;
  logic [WIDTH:0]   rsp_sum_q,   rsp_sum_d;
  // Round-robin priority pointer
  logic [IDW-1:0]   ptr_q, ptr_d;

  logic             adv;
  logic             any_valid;
  logic             found;
  logic [IDW:0]     cand;
  logic [IDW-1:0]   grant;
  logic [IDW-1:0]   ptr_next;

  // The whole pipeline moves only when the output slot is free or drained.
  assign adv       = !rsp_valid_q || rsp_ready;
  assign any_valid = |req_valid;

  // Scan ptr, ptr+1, ... with wrap; the one extra bit in cand keeps the
  // intermediate sum from overflowing before the modulo correction.
  always_comb begin : arb_scan
    grant = ptr_q;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW + 1)'(k);
      if (cand >= NREQ_EXT) begin
        cand = cand - NREQ_EXT;
      end
      if (!found && req_valid[cand[IDW-1:0]]) begin
        found = 1'b1;
        grant = cand[IDW-1:0];
      end
    end
  end

  assign ptr_next = (grant == LAST_ID) ? '0 : grant + IDW'(1);

  // Ready is withheld during reset so nothing is handed over while the
  // pipeline is being cleared.
  always_comb begin : ready_gen
    req_ready = '0;
    if (!rst && adv && any_valid) begin
      req_ready[grant] = 1'b1;
    end
  end

  always_comb begin : next_state
    s1_valid_d  = s1_valid_q;
    s1_id_d     = s1_id_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    ptr_d       = ptr_q;
    if (adv) begin
      rsp_valid_d = s1_valid_q;
      rsp_id_d    = s1_id_q;
      rsp_sum_d   = {1'b0, a_q} + {1'b0, b_q};
      if (any_valid) begin
        s1_valid_d = 1'b1;
        s1_id_d    = grant;
        a_d        = req_a[grant*WIDTH +: WIDTH];
        b_d        = req_b[grant*WIDTH +: WIDTH];
        ptr_d      = ptr_next;
      end else begin
        // Operand registers keep their last value; only the valid bit drops.
        s1_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin : regs
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      ptr_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_id_q     <= s1_id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      ptr_q       <= ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign busy      = s1_valid_q || rsp_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_adder_share_arbiter
// Description : Self-checking bench for adder_share_arbiter: directed vector
//               table, hand-written corner sequences and a randomized run
//               against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_share_arbiter;
  localparam int WIDTH = 138;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH:0]        rsp_sum;
  logic                  busy;

  always #5 clk = ~clk;

  adder_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Two-slot queue of in-flight results: slot 0 newest, slot 1 at the output.
  typedef struct {
    bit             v;
    int             id;
    logic [WIDTH:0] sum;
  } ent_t;
  ent_t pipe[2];
  int   m_ptr;
  bit   m_adv;
  int   m_g;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      pipe[i].v = 1'b0; pipe[i].id = 0; pipe[i].sum = '0;
    end
    m_ptr = 0;
  endtask

  task automatic model_check();
    int exp_ready;
    m_adv = !pipe[1].v || rsp_ready;
    m_g   = -1;
    if (m_adv) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx = (m_ptr + k) % NREQ;
        if (m_g < 0 && req_valid[idx]) m_g = idx;
      end
    end
    exp_ready = (m_g >= 0) ? (1 << m_g) : 0;
    chk("m_req_ready", req_ready, exp_ready);
    chk("m_rsp_valid", rsp_valid, pipe[1].v);
    if (pipe[1].v) begin
      chk("m_rsp_id", rsp_id, pipe[1].id);
      chk("m_rsp_sum", rsp_sum, pipe[1].sum);
    end
    chk("m_busy", busy, pipe[0].v || pipe[1].v);
  endtask

  task automatic model_update();
    logic [WIDTH:0] ea, eb;
    if (m_adv) begin
      pipe[1] = pipe[0];
      if (m_g >= 0) begin
        ea = {1'b0, req_a[m_g*WIDTH +: WIDTH]};
        eb = {1'b0, req_b[m_g*WIDTH +: WIDTH]};
        pipe[0].v   = 1'b1;
        pipe[0].id  = m_g;
        pipe[0].sum = ea + eb;
        m_ptr = (m_g + 1) % NREQ;
      end else begin
        pipe[0].v = 1'b0;
      end
    end
  endtask

  // Inputs are set just after a rising edge; outputs checked at the falling edge.
  task automatic half_check();
    @(negedge clk);
    model_check();
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [WIDTH-1:0] rnd_op();
    logic [159:0] r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    if ($urandom_range(7, 0) == 0) return '1;
    return r[WIDTH-1:0];
  endfunction

  task automatic rnd_operands();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = rnd_op();
      req_b[i*WIDTH +: WIDTH] = rnd_op();
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [NREQ-1:0]  valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    bit               rr;
    logic [NREQ-1:0]  exp_ready;
    bit               exp_rv;
    int               exp_id;
    logic [WIDTH:0]   exp_sum;
    bit               exp_busy;
  } vec_t;
  vec_t tbl[14];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [WIDTH:0] ones2;
    logic [WIDTH:0] pow;
    logic [WIDTH:0] held_sum;
    int             held_id;
    int             rr_seq[6];

    ones2 = '1; ones2[0] = 1'b0;              // 2^139 - 2
    pow   = '0; pow[WIDTH] = 1'b1;            // 2^138

    //            valid    a   b  rr exp_ready rv id sum busy
    tbl[0]  = '{4'b0100,  5,  7, 1, 4'b0100, 0, 0,  0, 0};
    tbl[1]  = '{4'b0000,  0,  0, 1, 4'b0000, 0, 0,  0, 1};
    tbl[2]  = '{4'b0000,  0,  0, 1, 4'b0000, 1, 2, 12, 1};
    tbl[3]  = '{4'b0000,  0,  0, 1, 4'b0000, 0, 0,  0, 0};
    tbl[4]  = '{4'b1111, 10,  1, 1, 4'b1000, 0, 0,  0, 0};
    tbl[5]  = '{4'b1111, 20,  2, 1, 4'b0001, 0, 0,  0, 1};
    tbl[6]  = '{4'b1111, 30,  3, 1, 4'b0010, 1, 3, 11, 1};
    tbl[7]  = '{4'b1010, 40,  4, 0, 4'b0000, 1, 0, 22, 1};
    tbl[8]  = '{4'b1010, 40,  4, 0, 4'b0000, 1, 0, 22, 1};
    tbl[9]  = '{4'b1010, 50,  5, 1, 4'b1000, 1, 0, 22, 1};
    tbl[10] = '{4'b1010, 60,  6, 1, 4'b0010, 1, 1, 33, 1};
    tbl[11] = '{4'b0000,  0,  0, 1, 4'b0000, 1, 3, 55, 1};
    tbl[12] = '{4'b0000,  0,  0, 1, 4'b0000, 1, 1, 66, 1};
    tbl[13] = '{4'b0000,  0,  0, 1, 4'b0000, 0, 0,  0, 0};

    // ---- reset state ----
    rst = 1'b1;
    req_valid = '1;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    req_valid = '0;
    rst = 1'b0;

    // ---- table ----
    for (int i = 0; i < 14; i++) begin
      req_valid = tbl[i].valid;
      req_a     = {NREQ{tbl[i].a}};
      req_b     = {NREQ{tbl[i].b}};
      rsp_ready = tbl[i].rr;
      half_check();
      chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].exp_ready);
      chk($sformatf("tbl%0d_rv", i), rsp_valid, tbl[i].exp_rv);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
      if (tbl[i].exp_rv) begin
        chk($sformatf("tbl%0d_id", i), rsp_id, tbl[i].exp_id);
        chk($sformatf("tbl%0d_sum", i), rsp_sum, tbl[i].exp_sum);
      end
      finish_cycle();
    end

    // ---- carry boundary ----
    rsp_ready = 1'b1;
    req_valid = 4'b0001; req_a = '1; req_b = '1;
    half_check(); finish_cycle();
    req_valid = 4'b0010; req_a = '1; req_b = {NREQ{138'd1}};
    half_check(); finish_cycle();
    req_valid = '0;
    half_check();
    chk("carry_ones_rv", rsp_valid, 1);
    chk("carry_ones_sum", rsp_sum, ones2);
    finish_cycle();
    half_check();
    chk("carry_pow_rv", rsp_valid, 1);
    chk("carry_pow_sum", rsp_sum, pow);
    finish_cycle();

    // ---- round-robin from reset, then async reset mid-flight ----
    do_reset();
    rr_seq = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < 6; i++) begin
      req_valid = 4'b1111;
      rnd_operands();
      half_check();
      chk("rr_grant", req_ready, 1 << rr_seq[i]);
      if (i >= 2) chk("rr_rsp_id", rsp_id, rr_seq[i-2]);
      finish_cycle();
    end
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_req_ready", req_ready, 0);
    req_valid = '0;
    model_reset();
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 4'b1111;
    rnd_operands();
    half_check();
    chk("post_rst_grant", req_ready, 4'b0001);
    finish_cycle();
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin half_check(); finish_cycle(); end

    // ---- pointer wrap and skip ----
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_valid = 4'b1010;
      rnd_operands();
      half_check();
      chk("skip_grant", req_ready, (i % 2 == 0) ? 4'b0010 : 4'b1000);
      finish_cycle();
    end
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin half_check(); finish_cycle(); end

    // ---- backpressure: 5-cycle stall mid-stream ----
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin rnd_operands(); half_check(); finish_cycle(); end
    held_sum = pipe[1].sum;
    held_id  = pipe[1].id;
    for (int i = 0; i < 5; i++) begin
      rsp_ready = 1'b0;
      rnd_operands();
      half_check();
      chk("stall_ready", req_ready, 0);
      chk("stall_sum", rsp_sum, held_sum);
      chk("stall_id", rsp_id, held_id);
      finish_cycle();
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin half_check(); finish_cycle(); end

    // ---- randomized run against the model ----
    for (int i = 0; i < 400; i++) begin
      req_valid = NREQ'($urandom);
      rsp_ready = ($urandom_range(3, 0) != 0);
      rnd_operands();
      half_check();
      finish_cycle();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin half_check(); finish_cycle(); end
    chk("final_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
